// File: rtl/ssd_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
// Digit geometry, scan state encoding and packed-bus digit extraction.
package ssd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 5;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int BUS_W      = NUM_DIGITS * DIGIT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        ON   = 2'd2
    } state_t;

    function automatic logic [DIGIT_W-1:0] digit_at(
        input logic [BUS_W-1:0] bus,
        input logic [IDX_W-1:0] i
    );
        return bus[i*DIGIT_W +: DIGIT_W];
    endfunction

endpackage

// File: rtl/ssd_slot_timer.sv
// Modulo-N counter with synchronous clear, count enable and terminal-count pulse.
// The pulse is combinational and only asserts on an enabled cycle at N-1.
module ssd_slot_timer #(
    parameter  int N = 2,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    assign tc = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit seven-segment scan sequencer with dead time, blanking, blinking
// and frame-boundary snapshots of the digit bus and masks.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEAD_CYC     = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [BUS_W-1:0]      digits,
    input  logic [NUM_DIGITS-1:0] blank_mask,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    output logic [NUM_DIGITS-1:0] an,
    output logic [DIGIT_W-1:0]    code,
    output logic                  frame_done
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SW-1:0] DEAD_LAST =
        SW'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
    localparam state_t SLOT_START = (DEAD_CYC == 0) ? ON : DEAD;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_t                 state, state_nx;
    logic [IDX_W-1:0]       idx, idx_nx;
    logic [BUS_W-1:0]       snap_digits, snap_digits_nx;
    logic [NUM_DIGITS-1:0]  snap_blank, snap_blank_nx;
    logic [NUM_DIGITS-1:0]  snap_blink, snap_blink_nx;
    logic                   blink_phase, blink_phase_nx;
    logic [NUM_DIGITS-1:0]  an_nx;
    logic [DIGIT_W-1:0]     code_nx;
    logic                   load;
    logic                   lit;

    logic                   active;
    logic                   frame_end;
    logic [SW-1:0]          slot_cnt;
    logic                   slot_tc;
    logic [FW-1:0]          frame_cnt;
    logic                   frame_tc;
    logic                   unused_frame;

    assign active       = (state != IDLE);
    assign frame_end    = en && (state == ON) && slot_tc && (idx == LAST_IDX);
    assign unused_frame = ^frame_cnt;

    ssd_slot_timer #(.N(SCAN_DIV)) u_slot (
        .clk (clk),
        .rst (rst),
        .clr (!en || !active),
        .en  (active),
        .cnt (slot_cnt),
        .tc  (slot_tc)
    );

    ssd_slot_timer #(.N(BLINK_FRAMES)) u_frame (
        .clk (clk),
        .rst (rst),
        .clr (!en),
        .en  (frame_end),
        .cnt (frame_cnt),
        .tc  (frame_tc)
    );

    always_comb begin
        state_nx       = state;
        idx_nx         = idx;
        load           = 1'b0;
        blink_phase_nx = blink_phase ^ frame_tc;

        if (!en) begin
            state_nx = IDLE;
            idx_nx   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    load     = 1'b1;
                    idx_nx   = '0;
                    state_nx = SLOT_START;
                end
                DEAD: begin
                    if (slot_cnt == DEAD_LAST) begin
                        state_nx = ON;
                    end
                end
                ON: begin
                    if (slot_tc) begin
                        idx_nx   = idx + 1'b1;
                        state_nx = SLOT_START;
                        load     = (idx == LAST_IDX);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                end
            endcase
        end

        snap_digits_nx = load ? digits     : snap_digits;
        snap_blank_nx  = load ? blank_mask : snap_blank;
        snap_blink_nx  = load ? blink_mask : snap_blink;
    end

    // Outputs are derived from next-cycle values so they line up with state.
    always_comb begin
        an_nx   = '1;
        code_nx = '0;
        lit     = !(snap_blank_nx[idx_nx] ||
                    (snap_blink_nx[idx_nx] && blink_phase_nx));
        if (state_nx != IDLE) begin
            code_nx = digit_at(snap_digits_nx, idx_nx);
        end
        if (state_nx == ON && lit) begin
            an_nx[idx_nx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            snap_digits <= '0;
            snap_blank  <= '0;
            snap_blink  <= '0;
            blink_phase <= 1'b0;
            an          <= '1;
            code        <= '0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            snap_digits <= snap_digits_nx;
            snap_blank  <= snap_blank_nx;
            snap_blink  <= snap_blink_nx;
            blink_phase <= blink_phase_nx;
            an          <= an_nx;
            code        <= code_nx;
            frame_done  <= frame_end;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with SCAN_DIV=8, DEAD_CYC=2, BLINK_FRAMES=2.
// Frames are 32 cycles: per slot 2 dark cycles then 6 lit cycles.
module tb_ssd_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic [19:0] digits;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic [3:0]  an;
    logic [4:0]  code;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    ssd_scan_ctrl #(
        .SCAN_DIV     (8),
        .DEAD_CYC     (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digits     (digits),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .an         (an),
        .code       (code),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks n cycles of a frame starting at its first DEAD cycle.
    task automatic frame(input string tag, input logic [19:0] dig,
                         input logic [3:0] dark, input logic fd0,
                         input int n, input int chg_at,
                         input logic [19:0] nd, input logic [3:0] nbk,
                         input logic [3:0] nbl);
        int slot;
        int pos;
        logic [3:0] ea;
        for (int c = 0; c < n; c++) begin
            slot = c / 8;
            pos  = c % 8;
            ea   = (pos < 2 || dark[slot]) ? 4'hF : ~(4'b0001 << slot);
            check($sformatf("%s an c%0d", tag, c), 32'(an), 32'(ea));
            check($sformatf("%s code c%0d", tag, c), 32'(code),
                  32'(dig[slot*5 +: 5]));
            check($sformatf("%s fd c%0d", tag, c), 32'(frame_done),
                  32'((c == 0) ? fd0 : 1'b0));
            if (c == chg_at) begin
                digits     = nd;
                blank_mask = nbk;
                blink_mask = nbl;
            end
            tick();
        end
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        digits     = 20'h0;
        blank_mask = 4'h0;
        blink_mask = 4'h0;
        tick();
        tick();
        check("rst an", 32'(an), 32'hF);
        check("rst code", 32'(code), 32'h0);
        check("rst fd", 32'(frame_done), 32'h0);

        rst    = 1'b0;
        en     = 1'b1;
        digits = 20'h8A4C3;
        tick();
        frame("f0", 20'h8A4C3, 4'h0, 1'b0, 32, 12, 20'hFFFFF, 4'h0, 4'h0);
        frame("f1", 20'hFFFFF, 4'h0, 1'b1, 32, 12, 20'h8A4C3, 4'b0100, 4'h0);
        frame("blank2", 20'h8A4C3, 4'b0100, 1'b1, 32, -1, 20'h0, 4'h0, 4'h0);
        frame("blank3", 20'h8A4C3, 4'b0100, 1'b1, 32, -1, 20'h0, 4'h0, 4'h0);
        frame("pre_rst", 20'h8A4C3, 4'b0100, 1'b1, 5, -1, 20'h0, 4'h0, 4'h0);

        rst = 1'b1;
        tick();
        check("midrst an", 32'(an), 32'hF);
        check("midrst code", 32'(code), 32'h0);
        check("midrst fd", 32'(frame_done), 32'h0);

        rst        = 1'b0;
        blank_mask = 4'b1000;
        blink_mask = 4'b1001;
        tick();
        for (int f = 0; f < 6; f++) begin
            frame($sformatf("blink%0d", f), 20'h8A4C3,
                  (f == 2 || f == 3) ? 4'b1001 : 4'b1000, (f > 0),
                  32, -1, 20'h0, 4'h0, 4'h0);
        end

        frame("pre_drop", 20'h8A4C3, 4'b1001, 1'b1, 13, -1, 20'h0, 4'h0, 4'h0);
        check("drop c13 an", 32'(an), 32'hD);
        check("drop c13 code", 32'(code), 32'h06);
        en = 1'b0;
        tick();
        for (int i = 0; i < 40; i++) begin
            check($sformatf("off an %0d", i), 32'(an), 32'hF);
            check($sformatf("off code %0d", i), 32'(code), 32'h0);
            check($sformatf("off fd %0d", i), 32'(frame_done), 32'h0);
            tick();
        end

        en = 1'b1;
        tick();
        frame("re0", 20'h8A4C3, 4'b1001, 1'b0, 32, -1, 20'h0, 4'h0, 4'h0);
        frame("re1", 20'h8A4C3, 4'b1001, 1'b1, 32, -1, 20'h0, 4'h0, 4'h0);
        frame("re2", 20'h8A4C3, 4'b1000, 1'b1, 32, -1, 20'h0, 4'h0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
